// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame constants.
// Also intended for the future receiver.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 104;
  localparam int unsigned UART_DATA_BITS            = 8;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Valid/ready byte handshake between an upstream producer and the UART transmitter.
interface uart_tx_serializer_if
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS = UART_DATA_BITS
) ();

  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready
  );

endinterface

// File: rtl/uart_bit_timer.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 while enabled and pulses bit_end on the
// last cycle of each bit. Held at zero while disabled so every bit starts aligned.
module uart_bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic bit_end
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear when idle or at the bit boundary, otherwise increment.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || (cnt_q == CntLast)) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_end = enable && (cnt_q == CntLast);

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter. Accepts one byte per valid/ready handshake and shifts it out
// LSB-first behind a start bit, followed by a stop bit. All outputs are registered.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DATA_BITS    = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_tx_serializer_if.slave  bus,
  output logic                 uart_tx
);

  localparam int unsigned BitCntW = $clog2(DATA_BITS + 1);
  localparam logic [BitCntW-1:0] BitCntLast = BitCntW'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [BitCntW-1:0]   bit_cnt_q, bit_cnt_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, ready_d;
  logic                 bit_end;
  logic                 handshake;

  assign handshake = bus.tx_valid && ready_q;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (state_q != StIdle),
    .bit_end(bit_end)
  );

  // Next state plus next values of the registered line and ready outputs.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    unique case (state_q)
      StIdle: begin
        tx_d    = 1'b1;
        ready_d = 1'b1;
        if (handshake) begin
          shift_d   = bus.tx_data;
          bit_cnt_d = '0;
          ready_d   = 1'b0;
          tx_d      = 1'b0;
          state_d   = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_cnt_q == BitCntLast) begin
            bit_cnt_d = '0;
            tx_d      = 1'b1;
            state_d   = StStop;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_d[0];
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          ready_d = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset abandons any frame and drops the latched byte.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
    end
  end

  assign uart_tx      = tx_q;
  assign bus.tx_ready = ready_q;

endmodule
